// File: rtl/drac_pkg.sv
// Shared load-size encodings and per-entry metadata for the dcache load tracker.
package drac_pkg;

  localparam logic [1:0] BYTE   = 2'd0;
  localparam logic [1:0] HALF   = 2'd1;
  localparam logic [1:0] WORD   = 2'd2;
  localparam logic [1:0] DOUBLE = 2'd3;

  // Alignment info kept per load; rd and killed live beside it in the tracker.
  typedef struct packed {
    logic [1:0] size;
    logic       is_unsigned;
    logic [2:0] off;
  } ld_meta_t;

endpackage

// File: rtl/lagarto_ld_align.sv
// Shifts raw 64-bit load data down by the byte offset and sign/zero-extends it to 64 bits.
module lagarto_ld_align
  import drac_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [2:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [63:0] result_o
);

  logic [63:0] shifted;

  always_comb begin
    shifted  = data_i >> {off_i, 3'b000};
    result_o = shifted;
    unique case (size_i)
      BYTE:    result_o = {{56{~unsigned_i & shifted[7]}}, shifted[7:0]};
      HALF:    result_o = {{48{~unsigned_i & shifted[15]}}, shifted[15:0]};
      WORD:    result_o = {{32{~unsigned_i & shifted[31]}}, shifted[31:0]};
      DOUBLE:  result_o = shifted;
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/lagarto_dcache_ld_tracker.sv
// In-order tracker of outstanding dcache loads; aligns each response and registers the writeback.
module lagarto_dcache_ld_tracker
  import drac_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RD_WIDTH = 6
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                ld_issue_valid_i,
  output logic                ld_issue_ready_o,
  input  logic [RD_WIDTH-1:0] ld_issue_rd_i,
  input  logic [1:0]          ld_issue_size_i,
  input  logic                ld_issue_unsigned_i,
  input  logic [2:0]          ld_issue_off_i,
  input  logic                flush_i,
  input  logic                rsp_valid_i,
  input  logic [63:0]         rsp_data_i,
  output logic                wb_valid_o,
  output logic [RD_WIDTH-1:0] wb_rd_o,
  output logic [63:0]         wb_data_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthC = (PtrW+1)'(DEPTH);

  logic [RD_WIDTH-1:0] rd_q   [DEPTH];
  ld_meta_t            meta_q [DEPTH];
  logic [DEPTH-1:0]    killed_q, killed_d;
  logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [PtrW:0]       count_q, count_d;
  logic                err_q, err_d;
  logic                wb_valid_q, wb_valid_d;
  logic [RD_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [63:0]         wb_data_q, wb_data_d;
  logic [63:0]         aligned;
  logic                push, pop;

  assign ld_issue_ready_o = count_q < DepthC;
  assign busy_o           = count_q != '0;
  assign push = ld_issue_valid_i & ld_issue_ready_o & ~flush_i;
  assign pop  = rsp_valid_i & (count_q != '0);

  lagarto_ld_align u_align (
    .data_i     (rsp_data_i),
    .off_i      (meta_q[head_q].off),
    .size_i     (meta_q[head_q].size),
    .unsigned_i (meta_q[head_q].is_unsigned),
    .result_o   (aligned)
  );

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    killed_d   = killed_q;
    err_d      = err_q | (rsp_valid_i & (count_q == '0));
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;

    if (pop) begin
      head_d = head_q + PtrW'(1);
      // A flush in the same cycle kills the head being popped as well.
      if (!killed_q[head_q] && !flush_i) begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q[head_q];
        wb_data_d  = aligned;
      end
    end
    // Marking unused slots too is harmless: push clears the bit it writes.
    if (flush_i) killed_d = '1;
    if (push) begin
      tail_d           = tail_q + PtrW'(1);
      killed_d[tail_q] = 1'b0;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW+1)'(1);
      2'b01:   count_d = count_q - (PtrW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      killed_q   <= '0;
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      killed_q   <= killed_d;
      err_q      <= err_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Payload storage needs no reset; count and killed gate every use of it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_q[tail_q]   <= ld_issue_rd_i;
      meta_q[tail_q] <= '{size: ld_issue_size_i, is_unsigned: ld_issue_unsigned_i,
                          off: ld_issue_off_i};
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;
  assign err_o      = err_q;

endmodule
